// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point normalisation datapath.
package fp_pkg;

    localparam int unsigned MAN_W    = 24;
    localparam int unsigned LZ_W     = 5;
    localparam int unsigned EXP_BIAS = 127;

    typedef struct packed {
        logic zero;
        logic uf;
    } norm_flags_t;

endpackage

// File: rtl/lzd_24bits.sv
// Leading-zero detector for a 24-bit word: p = count of leading zeros, v = word non-zero.
module lzd_24bits (
    input  logic [23:0] src,
    output logic [4:0]  p,
    output logic        v
);

    // Scan upwards so the highest set bit is the last assignment to win.
    always_comb begin
        p = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (src[i]) begin
                p = 5'(23 - i);
            end
        end
        v = |src;
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage post-normalisation pipeline: stage 1 captures the operand and its
// leading-zero count, stage 2 shifts the mantissa and adjusts/clamps the exponent.
module fp_norm_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_zero,
    output logic             out_uf,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
    logic [MAN_W-1:0] s1_man_q,   s1_man_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic [LZ_W-1:0]  s1_lz_q,    s1_lz_d;
    logic             s1_nz_q,    s1_nz_d;

    logic             out_valid_q, out_valid_d;
    logic             out_sign_q,  out_sign_d;
    logic [EXP_W-1:0] out_exp_q,   out_exp_d;
    logic [MAN_W-1:0] out_man_q,   out_man_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    norm_flags_t      out_flags_q, out_flags_d;

    logic             s2_adv_c;
    logic             s1_adv_c;
    logic             in_fire_c;
    logic [LZ_W-1:0]  lzd_p_c;
    logic             lzd_v_c;

    logic [EXP_W-1:0] lz_ext_c;
    logic [LZ_W-1:0]  shift_c;
    logic [EXP_W-1:0] nrm_exp_c;
    logic [MAN_W-1:0] nrm_man_c;
    norm_flags_t      nrm_flags_c;

    // Handshake: stage 2 frees up when empty or draining this cycle.
    assign s2_adv_c  = !out_valid_q | out_ready;
    assign s1_adv_c  = s1_valid_q & s2_adv_c;
    assign in_ready  = !s1_valid_q | s2_adv_c;
    assign in_fire_c = in_valid & in_ready;

    lzd_24bits u_lzd (
        .src (in_man),
        .p   (lzd_p_c),
        .v   (lzd_v_c)
    );

    // Stage 1 capture.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_man_d   = s1_man_q;
        s1_tag_d   = s1_tag_q;
        s1_lz_d    = s1_lz_q;
        s1_nz_d    = s1_nz_q;
        if (in_fire_c) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = in_sign;
            s1_exp_d   = in_exp;
            s1_man_d   = in_man;
            s1_tag_d   = in_tag;
            s1_lz_d    = lzd_p_c;
            s1_nz_d    = lzd_v_c;
        end else if (s1_adv_c) begin
            s1_valid_d = 1'b0;
        end
    end

    // Normalise: full shift when the exponent has room, else clamp to denormal.
    always_comb begin
        lz_ext_c    = EXP_W'(s1_lz_q);
        shift_c     = '0;
        nrm_exp_c   = '0;
        nrm_flags_c = '0;
        if (!s1_nz_q) begin
            nrm_flags_c.zero = 1'b1;
        end else if (s1_exp_q > lz_ext_c) begin
            shift_c   = s1_lz_q;
            nrm_exp_c = s1_exp_q - lz_ext_c;
        end else begin
            nrm_flags_c.uf = 1'b1;
            if (s1_exp_q != '0) begin
                shift_c = LZ_W'(s1_exp_q - EXP_W'(1));
            end
        end
        nrm_man_c = s1_man_q << shift_c;
    end

    // Stage 2 / output register; holds its contents while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_man_d   = out_man_q;
        out_tag_d   = out_tag_q;
        out_flags_d = out_flags_q;
        if (s2_adv_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sign_d  = s1_sign_q;
                out_exp_d   = nrm_exp_c;
                out_man_d   = nrm_man_c;
                out_tag_d   = s1_tag_q;
                out_flags_d = nrm_flags_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_man_q    <= '0;
            s1_tag_q    <= '0;
            s1_lz_q     <= '0;
            s1_nz_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_q    <= s1_man_d;
            s1_tag_q    <= s1_tag_d;
            s1_lz_q     <= s1_lz_d;
            s1_nz_q     <= s1_nz_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_man_q   <= out_man_d;
            out_tag_q   <= out_tag_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_man   = out_man_q;
    assign out_tag   = out_tag_q;
    assign out_zero  = out_flags_q.zero;
    assign out_uf    = out_flags_q.uf;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe: directed vectors, back-pressure,
// mid-stream reset and randomized traffic against an arithmetic reference model.
module tb_fp_norm_pipe;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] man;
        logic [3:0]  tag;
    } op_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] man;
        logic        zero;
        logic        uf;
        logic [3:0]  tag;
    } res_t;

    typedef struct {
        op_t  op;
        res_t res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [23:0] in_man;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready, out_sign, out_zero, out_uf;
    logic [7:0]  out_exp;
    logic [23:0] out_man;
    logic [3:0]  out_tag;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   inflight = 0;
    int   n_out = 0;
    res_t sb[$];
    logic stalled_prev = 1'b0;
    logic [39:0] held;

    fp_norm_pipe #(.EXP_W(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
        .out_zero(out_zero), .out_uf(out_uf), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [38:0] out_bus();
        return {out_sign, out_exp, out_man, out_zero, out_uf, out_tag};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: normalise by counting how far the mantissa sits below 2^23.
    function automatic res_t model(input op_t op);
        res_t r;
        int   lz;
        int   sh;
        r.sign = op.sign;
        r.tag  = op.tag;
        r.zero = 1'b0;
        r.uf   = 1'b0;
        if (op.man == 24'd0) begin
            r.man  = 24'd0;
            r.exp  = 8'd0;
            r.zero = 1'b1;
            return r;
        end
        lz = 0;
        while (longint'(op.man) < (longint'(1) << (23 - lz))) lz++;
        if (int'(op.exp) > lz) begin
            r.man = 24'(longint'(op.man) * (longint'(1) << lz));
            r.exp = 8'(int'(op.exp) - lz);
        end else begin
            sh    = (op.exp == 8'd0) ? 0 : int'(op.exp) - 1;
            r.man = 24'(longint'(op.man) * (longint'(1) << sh));
            r.exp = 8'd0;
            r.uf  = 1'b1;
        end
        return r;
    endfunction

    task automatic drive_op(input logic iv, input op_t op);
        in_valid = iv;
        in_sign  = op.sign;
        in_exp   = op.exp;
        in_man   = op.man;
        in_tag   = op.tag;
    endtask

    // One clock of streaming traffic; entered and left 1 time unit after a rising edge.
    task automatic step(input logic iv, input op_t op, input res_t exp_res,
                        input logic ordy, output logic fired);
        res_t e;
        drive_op(iv, op);
        out_ready = ordy;
        #1;
        check("in_ready", 64'(in_ready), 64'((inflight < 2) || ordy));
        if (stalled_prev) check("stall_hold", 64'({out_valid, out_bus()}), 64'(held));
        stalled_prev = out_valid & !ordy;
        held = {out_valid, out_bus()};
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_bus()), 64'(0));
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: tag %0h emitted with nothing outstanding", out_tag);
            end else begin
                e = sb.pop_front();
                check($sformatf("result_tag%0h", e.tag), 64'(out_bus()), 64'(e));
                inflight--;
            end
            n_out++;
        end
        fired = iv & in_ready;
        if (fired) begin
            sb.push_back(exp_res);
            inflight++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic f;
        op_t  z;
        z = '0;
        for (int i = 0; i < 20 && inflight > 0; i++) step(1'b0, z, '0, 1'b1, f);
        check(name, 64'(inflight), 64'(0));
    endtask

    // Exact-latency check for a single operand into an empty pipe.
    task automatic latency_check(input string name, input op_t op, input res_t r);
        stalled_prev = 1'b0;
        drive_op(1'b1, op);
        out_ready = 1'b0;
        #1;
        check({name, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_valid_1cyc"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check({name, "_valid_2cyc"}, 64'(out_valid), 64'(1));
        check({name, "_result"}, 64'(out_bus()), 64'(r));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_drained"}, 64'(out_valid), 64'(0));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_outputs"}, 64'(out_bus()), 64'(0));
        check({name, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    vec_t vecs[9];

    initial begin
        logic f;
        op_t  op;
        op_t  cur;
        int   next;
        int   base;
        int   cyc;

        // {sign, exp, man, tag} -> {sign, exp, man, zero, uf, tag}
        vecs[0] = '{'{1'b0, 8'd130, 24'h800000, 4'h1}, '{1'b0, 8'd130, 24'h800000, 1'b0, 1'b0, 4'h1}};
        vecs[1] = '{'{1'b1, 8'd100, 24'h000C00, 4'h2}, '{1'b1, 8'd88,  24'hC00000, 1'b0, 1'b0, 4'h2}};
        vecs[2] = '{'{1'b0, 8'd5,   24'h000001, 4'h3}, '{1'b0, 8'd0,   24'h000010, 1'b0, 1'b1, 4'h3}};
        vecs[3] = '{'{1'b1, 8'd77,  24'h000000, 4'h4}, '{1'b1, 8'd0,   24'h000000, 1'b1, 1'b0, 4'h4}};
        vecs[4] = '{'{1'b0, 8'd0,   24'h000100, 4'h5}, '{1'b0, 8'd0,   24'h000100, 1'b0, 1'b1, 4'h5}};
        vecs[5] = '{'{1'b0, 8'd1,   24'h400000, 4'h6}, '{1'b0, 8'd0,   24'h400000, 1'b0, 1'b1, 4'h6}};
        vecs[6] = '{'{1'b1, 8'd13,  24'h000C00, 4'h7}, '{1'b1, 8'd1,   24'hC00000, 1'b0, 1'b0, 4'h7}};
        vecs[7] = '{'{1'b0, 8'd12,  24'h000C00, 4'h8}, '{1'b0, 8'd0,   24'h600000, 1'b0, 1'b1, 4'h8}};
        vecs[8] = '{'{1'b1, 8'd255, 24'hFFFFFF, 4'h9}, '{1'b1, 8'd255, 24'hFFFFFF, 1'b0, 1'b0, 4'h9}};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive_op(1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");

        latency_check("latency", vecs[0].op, vecs[0].res);

        // Directed vectors back to back at full throughput.
        foreach (vecs[i]) step(1'b1, vecs[i].op, vecs[i].res, 1'b1, f);
        drain("vec_drain");

        // Back-pressure: tags 0..9, out_ready low for stream cycles 3..7.
        base = n_out;
        next = 0;
        for (cyc = 0; cyc < 60 && (n_out - base) < 10; cyc++) begin
            op = '{1'b0, 8'd100, 24'h000001 << (2 * next), 4'(next)};
            step(next < 10, op, model(op), !(cyc >= 3 && cyc <= 7), f);
            if (f) next++;
        end
        check("bp_count", 64'(n_out - base), 64'(10));
        check("bp_empty", 64'(sb.size()), 64'(0));

        // Randomized traffic against the model.
        cur = '{1'($urandom), 8'($urandom), 24'($urandom), 4'($urandom)};
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, cur, model(cur), $urandom_range(0, 3) != 0, f);
            if (f) begin
                cur.sign = 1'($urandom);
                cur.exp  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
                cur.man  = 24'($urandom) & (24'hFFFFFF >> $urandom_range(0, 24));
                cur.tag  = 4'($urandom);
            end
        end
        drain("rand_drain");

        // Reset with both stages full: in-flight operands must vanish.
        step(1'b1, '{1'b1, 8'd50, 24'h00ABCD, 4'hA}, '0, 1'b0, f);
        step(1'b1, '{1'b0, 8'd60, 24'h001234, 4'hB}, '0, 1'b0, f);
        step(1'b0, '0, '0, 1'b0, f);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        inflight     = 0;
        stalled_prev = 1'b0;
        check_reset_state("midreset");

        op = '{1'b1, 8'd100, 24'h000C00, 4'hC};
        latency_check("post_reset", op, model(op));
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, f);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Two-stage pipelined post-normalisation stage for 24-bit mantissas (single-precision significand incl. hidden bit).
- Sits directly downstream of lzd_24bits and instantiates it internally in stage 1.
- Left-shifts the mantissa by the leading-zero count and adjusts the biased exponent, clamping to denormal on underflow.
- Uses a valid/ready handshake on both sides, with full-throughput backpressure.

Parameters:
- EXP_W, 8: biased exponent width.
- TAG_W, 4: width of the opaque sideband tag carried alongside each operand.

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  stage can accept the input operand
- in_sign  in  1  sign bit
- in_exp  in  EXP_W  biased exponent before normalisation
- in_man  in  24  unnormalised mantissa
- in_tag  in  TAG_W  sideband tag, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sign  out  1  sign bit, passed through
- out_exp  out  EXP_W  adjusted biased exponent
- out_man  out  24  normalised mantissa
- out_zero  out  1  input mantissa was zero
- out_uf  out  1  result clamped to denormal (exponent underflow)
- out_tag  out  TAG_W  tag associated with this result

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - s1_valid=0, s2_valid=0.
  - All registered outputs forced to 0: out_valid, out_sign, out_exp, out_man, out_zero, out_uf, out_tag.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight operands; none are emitted.
- lzd_24bits contract: src=in_man; p = leading-zero count (0..23); v=1 iff in_man != 0.
- Stage 1 (on input handshake in_valid & in_ready):
  - Registers sign, exp, man, tag, lz=p, nz=v.
  - Sets s1_valid=1.
- Stage 2 computation from the stage-1 registers:
  - nz=0: man=0, exp=0, zero=1, uf=0.
  - nz=1 and exp > lz: man = man << lz; exp = exp - lz; zero=0, uf=0. The MSB of out_man is 1.
  - nz=1 and exp <= lz:
    - shift = (exp==0) ? 0 : exp-1
    - man = man << shift; exp=0; uf=1; zero=0.
- Arithmetic:
  - Exponent compare/subtract is unsigned, with lz zero-extended to EXP_W.
  - The shift never exceeds 23; bits shifted out are zero by construction.
- Handshake and flow control:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances into s2 when s1_valid and s2 advances.
  - in_ready = !s1_valid | (s2 advances). in_ready is combinational from out_ready.
  - out_valid = s2_valid.
  - Output register contents stay stable while out_valid & !out_ready.
- Latency and throughput:
  - 2 cycles from the input handshake to out_valid.
  - Throughput is 1 operand per cycle with out_ready held high.
- Simultaneous events: input acceptance, stage-1→stage-2 transfer and output drain can all occur in the same cycle with no bubble.
- Ordering: strictly in order. The tag always travels with its own operand.
- Back-pressure: out_ready held 0 fills both stages, then in_ready=0. No operand is dropped or duplicated.

Decomposition:
- Shared package fp_pkg holds:
  - MAN_W=24, LZ_W=5, EXP_BIAS=127
  - typedef norm_flags_t {zero, uf}
- Sub-module: the existing lzd_24bits, instantiated unchanged in stage 1.
- The barrel shift and exponent logic stay inline in stage 2; no further sub-module.

Test Plan:
- Already normalised: man=24'h800000, exp=8'd130 → out_man=24'h800000, out_exp=130, zero=0, uf=0, out_valid exactly 2 cycles after the handshake.
- Normal shift: man=24'h000C00, exp=8'd100 → lz=12, out_man=24'hC00000, out_exp=88, uf=0.
- Underflow clamp: man=24'h000001, exp=8'd5 → lz=23 ≥ 5, shift=4, out_man=24'h000010, out_exp=0, uf=1.
- Zero, exp=0 and boundary cases:
  - man=0, exp=8'd77 → out_man=0, out_exp=0, zero=1, uf=0.
  - man=24'h000100, exp=0 → shift 0, out_man=24'h000100, uf=1.
  - man=24'h400000, exp=1 → uf=1, exp=0, out_man unchanged.
- Back-pressure and throughput:
  - Stream tags 0..9 with out_ready low for cycles 3..7.
  - in_ready drops after 2 accepted-but-undrained operands.
  - out_* stays stable while stalled.
  - All 10 results emerge in order, with matching tags and no loss.
- Reset mid-stream: assert rst_n=0 for 1 cycle with both stages full → out_valid=0 and outputs 0 the next cycle; the previously in-flight tags never appear; the next accepted operand emerges normally 2 cycles later.
